// File: rtl/wb_signal_generator.sv
// rtl/wb_signal_generator.sv - Wishbone square-wave/burst generator; SIGGEN_IRQ_EN adds irq_o
module wb_signal_generator #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0300,
  parameter int          CNT_W     = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        signal_o,
  output logic        busy_o
`ifdef SIGGEN_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {IDLE, PHASE_A, PHASE_B} state_t;

  state_t             state;
  logic               en, burst, pol, done, irq_bit;
  logic [CNT_W-1:0]   half_period, burst_count, shadow, half_cnt, remaining;
  logic [CNT_W-1:0]   hp_new, bc_new;
  logic [CNT_W:0]     cnt_inc;
  logic               hit, accept, wr, hp_err, st_err, bus_err, do_write;
  logic               ctrl_wr, clr_done, pol_nxt, half_end, unused_addr;
  logic [1:0]         reg_sel;
  logic [31:0]        mask, wdata, rdata;

`ifdef SIGGEN_IRQ_EN
  logic irq_en;
  assign irq_bit = irq_en;
`else
  assign irq_bit = 1'b0;
`endif

  assign rty_o       = 1'b0;
  assign unused_addr = ^addr_i[1:0];
  assign hit      = cyc_i & stb_i & (addr_i[31:4] == BASE_ADDR[31:4]);
  assign accept   = hit & ~ack_o & ~err_o;
  assign wr       = accept & we_i;
  assign reg_sel  = addr_i[3:2];
  assign mask     = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign wdata    = dat_i & mask;
  assign hp_new   = CNT_W'((32'(half_period) & ~mask) | wdata);
  assign bc_new   = CNT_W'((32'(burst_count) & ~mask) | wdata);
  assign hp_err   = wr & (reg_sel == 2'd1) & sel_i[0] & (wdata[CNT_W-1:0] == '0);
  assign st_err   = wr & (reg_sel == 2'd3) & ~wdata[1] & (|(wdata & ~32'h2));
  assign bus_err  = hp_err | st_err;
  assign do_write = wr & ~bus_err;
  assign ctrl_wr  = do_write & (reg_sel == 2'd0) & sel_i[0];
  assign clr_done = do_write & (reg_sel == 2'd3) & wdata[1];
  // A POL write must show on the level driven at the same edge
  assign pol_nxt  = ctrl_wr ? dat_i[2] : pol;
  assign cnt_inc  = {1'b0, half_cnt} + (CNT_W+1)'(1);
  assign half_end = cnt_inc >= {1'b0, shadow};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata = {28'd0, irq_bit, pol, burst, en};
      2'd1:    rdata = 32'(half_period);
      2'd2:    rdata = 32'(burst_count);
      default: rdata = (32'(remaining) << 8) | {30'd0, done, busy_o};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      dat_o       <= '0;
      signal_o    <= 1'b0;
      busy_o      <= 1'b0;
      en          <= 1'b0;
      burst       <= 1'b0;
      pol         <= 1'b0;
      done        <= 1'b0;
      half_period <= CNT_W'(1);
      burst_count <= '0;
      shadow      <= CNT_W'(1);
      half_cnt    <= '0;
      remaining   <= '0;
`ifdef SIGGEN_IRQ_EN
      irq_en      <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
      if (accept) begin
        if (bus_err) err_o <= 1'b1;
        else         ack_o <= 1'b1;
        if (!we_i)   dat_o <= rdata;
      end

      // Clear precedes the FSM so a same-cycle DONE set wins
      if (clr_done) done <= 1'b0;

      if (state != IDLE && !en) begin
        state    <= IDLE;
        busy_o   <= 1'b0;
        half_cnt <= '0;
        signal_o <= pol_nxt;
      end else begin
        case (state)
          IDLE: begin
            half_cnt <= '0;
            signal_o <= pol_nxt;
            if (en) begin
              if (burst && burst_count == '0) begin
                done <= 1'b1;
                en   <= 1'b0;
              end else begin
                shadow    <= half_period;
                remaining <= burst_count;
                state     <= PHASE_A;
                busy_o    <= 1'b1;
                signal_o  <= ~pol_nxt;
              end
            end
          end
          PHASE_A: begin
            if (half_end) begin
              half_cnt <= '0;
              state    <= PHASE_B;
              signal_o <= pol_nxt;
            end else begin
              half_cnt <= cnt_inc[CNT_W-1:0];
              signal_o <= ~pol_nxt;
            end
          end
          PHASE_B: begin
            if (!half_end) begin
              half_cnt <= cnt_inc[CNT_W-1:0];
              signal_o <= pol_nxt;
            end else begin
              half_cnt <= '0;
              if (burst && remaining <= CNT_W'(1)) begin
                remaining <= '0;
                state     <= IDLE;
                busy_o    <= 1'b0;
                done      <= 1'b1;
                en        <= 1'b0;
                signal_o  <= pol_nxt;
              end else begin
                if (burst) remaining <= remaining - CNT_W'(1);
                shadow   <= half_period;
                state    <= PHASE_A;
                signal_o <= ~pol_nxt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Bus writes come last so software wins over the FSM's EN clear
      if (do_write) begin
        case (reg_sel)
          2'd0: if (sel_i[0]) begin
            en    <= dat_i[0];
            burst <= dat_i[1];
            pol   <= dat_i[2];
`ifdef SIGGEN_IRQ_EN
            irq_en <= dat_i[3];
`endif
          end
          2'd1:    half_period <= hp_new;
          2'd2:    burst_count <= bc_new;
          default: ;
        endcase
      end
    end
  end

`ifdef SIGGEN_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) irq_o <= 1'b0;
    else        irq_o <= done & irq_en;
  end
`endif

endmodule
